// File: rtl/uart_bus_master.sv
// uart_bus_master: serial debug/loader bus initiator.
// Pops command bytes from the uart RX FIFO, takes the bus from the 65c02 via bus_req_o/bus_gnt_i,
// performs one single-byte read or write, then pushes one reply byte into the uart TX FIFO.
//   'W' AH AL D -> mem[{AH,AL}] = D, reply ACK
//   'R' AH AL   -> reply mem[{AH,AL}]
//   other       -> reply NAK
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   rx_empty_i, r_data_i      RX FIFO status / head byte;  rd_uart_o pops the head
//   tx_full_i                 TX FIFO full;  w_data_o/wr_uart_o push a reply byte
//   bus_req_o, bus_gnt_i      bus ownership handshake with the CPU
//   bus_addr_o, bus_en_o, bus_we_o, bus_dout_o, bus_din_i   memory port (sync RAM)
//   busy_o                    high whenever a command is in progress
module uart_bus_master #(
    parameter int unsigned Timeout = 200000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_empty_i,
    input  logic [7:0]  r_data_i,
    output logic        rd_uart_o,
    input  logic        tx_full_i,
    output logic [7:0]  w_data_o,
    output logic        wr_uart_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic [15:0] bus_addr_o,
    output logic        bus_en_o,
    output logic        bus_we_o,
    output logic [7:0]  bus_dout_o,
    input  logic [7:0]  bus_din_i,
    output logic        busy_o
);

    localparam logic [7:0] OpWrite = 8'h57;
    localparam logic [7:0] OpRead  = 8'h52;
    localparam logic [7:0] Ack     = 8'h06;
    localparam logic [7:0] Nak     = 8'h15;

    typedef enum logic [2:0] {
        StIdle, StGetAh, StGetAl, StGetD, StReq, StAccess, StCapture, StReply
    } state_e;

    state_e      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  reply_q, reply_d;
    logic [31:0] tmo_q, tmo_d;
    logic        in_get;

    assign in_get = (state_q == StGetAh) || (state_q == StGetAl) || (state_q == StGetD);

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        reply_d    = reply_q;
        tmo_d      = tmo_q;
        rd_uart_o  = 1'b0;
        wr_uart_o  = 1'b0;
        bus_req_o  = 1'b0;
        bus_en_o   = 1'b0;
        bus_we_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmo_d = 32'd0;
                if (!rx_empty_i) begin
                    rd_uart_o = 1'b1;
                    if (r_data_i == OpWrite || r_data_i == OpRead) begin
                        is_write_d = (r_data_i == OpWrite);
                        state_d    = StGetAh;
                    end else begin
                        reply_d = Nak;
                        state_d = StReply;
                    end
                end
            end
            StGetAh: begin
                if (!rx_empty_i) begin
                    rd_uart_o    = 1'b1;
                    addr_d[15:8] = r_data_i;
                    state_d      = StGetAl;
                end
            end
            StGetAl: begin
                if (!rx_empty_i) begin
                    rd_uart_o   = 1'b1;
                    addr_d[7:0] = r_data_i;
                    state_d     = is_write_q ? StGetD : StReq;
                end
            end
            StGetD: begin
                if (!rx_empty_i) begin
                    rd_uart_o = 1'b1;
                    dout_d    = r_data_i;
                    state_d   = StReq;
                end
            end
            StReq: begin
                bus_req_o = 1'b1;
                if (bus_gnt_i) state_d = StAccess;
            end
            StAccess: begin
                // Strobe completes even if the grant has already dropped.
                bus_req_o = 1'b1;
                bus_en_o  = 1'b1;
                bus_we_o  = is_write_q;
                if (is_write_q) begin
                    reply_d = Ack;
                    state_d = StReply;
                end else begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                // Synchronous RAM: read data is valid the cycle after the strobe.
                bus_req_o = 1'b1;
                reply_d   = bus_din_i;
                state_d   = StReply;
            end
            StReply: begin
                if (!tx_full_i) begin
                    wr_uart_o = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Inter-byte timeout: only while a command is partially received.
        if (in_get) begin
            if (!rx_empty_i) begin
                tmo_d = 32'd0;
            end else if (tmo_q >= Timeout - 32'd1) begin
                tmo_d   = 32'd0;
                state_d = StIdle;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            is_write_q <= 1'b0;
            addr_q     <= 16'h0000;
            dout_q     <= 8'h00;
            reply_q    <= 8'h00;
            tmo_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            reply_q    <= reply_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus_addr_o = addr_q;
    assign bus_dout_o = dout_q;
    assign w_data_o   = reply_q;
    assign busy_o     = (state_q != StIdle);

endmodule
